// File: rtl/udp_tx_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : udp_tx_ctrl_pkg
// Brief    : Shared constants for the UDP transmit feeder (FSM states, payload cap)
// Revision : 1.0 - initial release
//==============================================================================
package udp_tx_ctrl_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_send  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam int UDP_MAX_PAYLOAD = 1472;

endpackage
`default_nettype wire

// File: rtl/udp_tx_ctrl_sync_fifo.sv
`default_nettype none
//==============================================================================
// Module   : udp_sync_fifo
// Brief    : Single-clock FIFO with registered read data, full/empty and level
// Revision : 1.0 - initial release
//==============================================================================
module udp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [2**AW];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_rd_data;
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_tx_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : udp_tx_ctrl
// Brief    : Buffers committed user frames and feeds them byte-wise to eth udp_tx_*
// Revision : 1.0 - initial release
//==============================================================================
module udp_tx_ctrl
    import udp_tx_ctrl_pkg::*;
#(
    parameter int DATA_AW = 11,
    parameter int LEN_AW  = 2,
    parameter int MAX_LEN = UDP_MAX_PAYLOAD
) (
    input  logic            gmii_tx_clk,
    input  logic            rst,
    input  logic [7:0]      wr_data,
    input  logic            wr_vld,
    input  logic            wr_last,
    output logic            wr_rdy,
    input  logic            tx_rdy,
    output logic            udp_tx_en,
    output logic [15:0]     udp_tx_data_num,
    input  logic            udp_tx_req,
    output logic [7:0]      udp_tx_data,
    output logic [LEN_AW:0] frame_pend,
    output logic            req_err
);

    logic [1:0]       r_state;
    logic [15:0]      r_wr_cnt;
    logic [15:0]      r_sent_cnt;
    logic             r_seen_low;
    logic             r_zero_data;
    logic             r_req_err;

    logic             w_wr_acc;
    logic             w_commit;
    logic [15:0]      w_len_wdata;
    logic             w_start_pop;
    logic             w_good_req;
    logic             w_byte_full;
    logic             w_byte_empty;
    logic [DATA_AW:0] w_byte_level_unused;
    logic [7:0]       w_byte_rdata;
    logic             w_len_full;
    logic             w_len_empty;

    assign wr_rdy      = ~rst & ~w_byte_full & ~w_len_full;
    assign w_wr_acc    = wr_vld & wr_rdy;
    assign w_commit    = w_wr_acc & (wr_last | (r_wr_cnt == 16'(MAX_LEN - 1)));
    assign w_len_wdata = r_wr_cnt + 16'd1;
    assign w_start_pop = (r_state == c_st_idle) & ~w_len_empty & tx_rdy;
    assign w_good_req  = udp_tx_req & (r_state == c_st_send)
                       & (r_sent_cnt != udp_tx_data_num) & ~w_byte_empty;

    assign udp_tx_en   = (r_state == c_st_start);
    assign udp_tx_data = r_zero_data ? 8'h00 : w_byte_rdata;
    assign req_err     = r_req_err;

    udp_sync_fifo #(
        .WIDTH (8),
        .AW    (DATA_AW)
    ) u_byte_buf (
        .clk       (gmii_tx_clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_data (wr_data),
        .i_rd_en   (w_good_req),
        .o_rd_data (w_byte_rdata),
        .o_full    (w_byte_full),
        .o_empty   (w_byte_empty),
        .o_level   (w_byte_level_unused)
    );

    // Length queue read data doubles as udp_tx_data_num: it only moves on a START pop.
    udp_sync_fifo #(
        .WIDTH (16),
        .AW    (LEN_AW)
    ) u_len_q (
        .clk       (gmii_tx_clk),
        .rst       (rst),
        .i_wr_en   (w_commit),
        .i_wr_data (w_len_wdata),
        .i_rd_en   (w_start_pop),
        .o_rd_data (udp_tx_data_num),
        .o_full    (w_len_full),
        .o_empty   (w_len_empty),
        .o_level   (frame_pend)
    );

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_wr_cnt    <= '0;
            r_sent_cnt  <= '0;
            r_seen_low  <= 1'b0;
            r_zero_data <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_cnt <= w_commit ? 16'd0 : r_wr_cnt + 16'd1;
            end
            if (w_good_req) begin
                r_zero_data <= 1'b0;
            end else if (udp_tx_req) begin
                r_zero_data <= 1'b1;
                r_req_err   <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_start_pop) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_sent_cnt <= '0;
                    r_state    <= c_st_send;
                end
                c_st_send: begin
                    if (w_good_req) begin
                        r_sent_cnt <= r_sent_cnt + 16'd1;
                        if (r_sent_cnt + 16'd1 == udp_tx_data_num) begin
                            r_seen_low <= 1'b0;
                            r_state    <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    // eth must drop tx_rdy (CRC/IFG) and raise it again before the next frame.
                    if (!tx_rdy) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_udp_tx_ctrl
// Brief    : Randomised self-checking bench for udp_tx_ctrl with a frame-level model
// Revision : 1.0 - initial release
//==============================================================================
module tb_udp_tx_ctrl;

    localparam int c_max_len = 1472;
    localparam int c_buf_sz  = 2048;
    localparam int c_lenq_sz = 4;

    logic        gmii_tx_clk;
    logic        rst;
    logic [7:0]  wr_data;
    logic        wr_vld;
    logic        wr_last;
    logic        wr_rdy;
    logic        tx_rdy;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data_num;
    logic        udp_tx_req;
    logic [7:0]  udp_tx_data;
    logic [2:0]  frame_pend;
    logic        req_err;

    int errors = 0;
    int checks = 0;
    int last_wait;

    // Reference model: bytes of the open frame, then committed lengths/bytes in order.
    logic [7:0] open_q[$];
    int         mdl_lens[$];
    logic [7:0] mdl_bytes[$];
    int         cap_lens[$];
    logic [7:0] cap_bytes[$];

    udp_tx_ctrl u_dut (
        .gmii_tx_clk     (gmii_tx_clk),
        .rst             (rst),
        .wr_data         (wr_data),
        .wr_vld          (wr_vld),
        .wr_last         (wr_last),
        .wr_rdy          (wr_rdy),
        .tx_rdy          (tx_rdy),
        .udp_tx_en       (udp_tx_en),
        .udp_tx_data_num (udp_tx_data_num),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_data     (udp_tx_data),
        .frame_pend      (frame_pend),
        .req_err         (req_err)
    );

    initial gmii_tx_clk = 1'b0;
    always #5 gmii_tx_clk = ~gmii_tx_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    function automatic void clear_model();
        open_q.delete();
        mdl_lens.delete();
        mdl_bytes.delete();
        cap_lens.delete();
        cap_bytes.delete();
    endfunction

    function automatic void model_accept(logic [7:0] d, logic l);
        open_q.push_back(d);
        if (l || open_q.size() == c_max_len) begin
            mdl_lens.push_back(open_q.size());
            foreach (open_q[i]) mdl_bytes.push_back(open_q[i]);
            open_q.delete();
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        wr_vld = 1'b0;
        wr_last = 1'b0;
        udp_tx_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic l, input int max_wait, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        wr_data = d;
        wr_last = l;
        wr_vld = 1'b1;
        while (!ok && waited < max_wait) begin
            if (wr_rdy === 1'b1) ok = 1'b1;
            tick();
            waited++;
        end
        wr_vld = 1'b0;
        wr_last = 1'b0;
        if (ok) model_accept(d, l);
    endtask

    // eth-side behaviour: wait for the start pulse, request bytes, then drop tx_rdy for CRC/IFG.
    task automatic eth_serve(input int max_wait, input int stop_after, input bit drop_rdy, output bit got_en);
        int waited;
        int n;
        int k;
        got_en = 1'b0;
        waited = 0;
        while (!got_en && waited < max_wait) begin
            if (udp_tx_en === 1'b1) got_en = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        last_wait = waited;
        if (!got_en) return;
        n = int'(udp_tx_data_num);
        cap_lens.push_back(n);
        tick();
        k = (n > c_max_len) ? c_max_len : n;
        if (stop_after >= 0 && stop_after < k) k = stop_after;
        for (int i = 0; i < k; i++) begin
            udp_tx_req = 1'b1;
            tick();
            udp_tx_req = 1'b0;
            cap_bytes.push_back(udp_tx_data);
            repeat ($urandom_range(0, 1)) tick();
        end
        if (drop_rdy && k == n) begin
            tx_rdy = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            tx_rdy = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (wr_rdy !== 1'b0) begin errors++; $display("FAIL reset_wr_rdy_in_rst: got %b expected 0", wr_rdy); end
        rst = 1'b0;
        tick();
        checks++;
        if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy_after: got %b expected 1", wr_rdy); end
        checks++;
        if (udp_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", udp_tx_en); end
        checks++;
        if (udp_tx_data_num !== 16'd0) begin errors++; $display("FAIL reset_data_num: got %0d expected 0", udp_tx_data_num); end
        checks++;
        if (udp_tx_data !== 8'd0) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", udp_tx_data); end
        checks++;
        if (frame_pend !== 3'd0) begin errors++; $display("FAIL reset_frame_pend: got %0d expected 0", frame_pend); end
        checks++;
        if (req_err !== 1'b0) begin errors++; $display("FAIL reset_req_err: got %b expected 0", req_err); end
        clear_model();
    endtask

    task automatic test_basic();
        bit ok;
        bit got;
        tx_rdy = 1'b1;
        for (int i = 0; i < 10; i++) write_byte(8'(i), i == 9, 100, ok);
        eth_serve(50, -1, 1'b1, got);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_en: got no pulse expected udp_tx_en"); end
        checks++;
        if (last_wait != 1) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 1 after commit", last_wait); end
        checks++;
        if (cap_lens.size() != 1 || cap_lens[0] != 10) begin
            errors++; $display("FAIL basic_num: got %0d frames (first %0d) expected 1 frame of 10", cap_lens.size(), (cap_lens.size() > 0) ? cap_lens[0] : -1);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap_bytes.size() || cap_bytes[i] !== 8'(i)) begin
                errors++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, (i < cap_bytes.size()) ? cap_bytes[i] : 8'hxx, 8'(i));
            end
        end
        checks++;
        if (req_err !== 1'b0) begin errors++; $display("FAIL basic_req_err: got %b expected 0", req_err); end
        checks++;
        if (frame_pend !== 3'd0) begin errors++; $display("FAIL basic_pend: got %0d expected 0", frame_pend); end
    endtask

    task automatic test_random();
        int nfr;
        int misses;
        int timeouts;
        int nbad;
        nfr = 6;
        misses = 0;
        timeouts = 0;
        tx_rdy = 1'b1;
        fork
            begin : writer
                bit ok;
                int len;
                for (int f = 0; f < nfr; f++) begin
                    len = $urandom_range(1, 60);
                    for (int b = 0; b < len; b++) begin
                        write_byte(8'($urandom), b == len - 1, 3000, ok);
                        if (!ok) timeouts++;
                        repeat ($urandom_range(0, 2)) tick();
                    end
                end
            end
            begin : server
                bit got;
                for (int f = 0; f < nfr; f++) begin
                    eth_serve(5000, -1, 1'b1, got);
                    if (!got) misses++;
                end
            end
        join
        checks++;
        if (misses != 0 || timeouts != 0) begin errors++; $display("FAIL rand_handshake: got %0d missed starts %0d write timeouts expected 0 0", misses, timeouts); end
        nbad = (cap_lens.size() != mdl_lens.size()) ? 1 : 0;
        foreach (mdl_lens[i]) if (i >= cap_lens.size() || cap_lens[i] != mdl_lens[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL rand_lengths: got %0d frames (%0d wrong) expected %0d frames", cap_lens.size(), nbad, mdl_lens.size()); end
        nbad = (cap_bytes.size() != mdl_bytes.size()) ? 1 : 0;
        foreach (mdl_bytes[i]) if (i >= cap_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL rand_bytes: got %0d bytes (%0d wrong) expected %0d bytes", cap_bytes.size(), nbad, mdl_bytes.size()); end
        checks++;
        if (frame_pend !== 3'd0) begin errors++; $display("FAIL rand_pend: got %0d expected 0", frame_pend); end
    endtask

    task automatic test_autosplit();
        int timeouts;
        int misses;
        int nbad;
        bit got3;
        timeouts = 0;
        misses = 0;
        tx_rdy = 1'b1;
        fork
            begin : writer
                bit ok;
                for (int b = 0; b < 3000; b++) begin
                    write_byte(8'($urandom), 1'b0, 5000, ok);
                    if (!ok) timeouts++;
                end
            end
            begin : server
                bit got;
                for (int f = 0; f < 2; f++) begin
                    eth_serve(8000, -1, 1'b1, got);
                    if (!got) misses++;
                end
            end
        join
        checks++;
        if (misses != 0 || timeouts != 0) begin errors++; $display("FAIL split_handshake: got %0d missed starts %0d write timeouts expected 0 0", misses, timeouts); end
        nbad = (cap_lens.size() != mdl_lens.size()) ? 1 : 0;
        foreach (mdl_lens[i]) if (i >= cap_lens.size() || cap_lens[i] != mdl_lens[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL split_lengths: got %0d frames (first %0d) expected %0d frames of %0d", cap_lens.size(), (cap_lens.size() > 0) ? cap_lens[0] : -1, mdl_lens.size(), c_max_len); end
        nbad = (cap_bytes.size() != mdl_bytes.size()) ? 1 : 0;
        foreach (mdl_bytes[i]) if (i >= cap_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL split_bytes: got %0d bytes (%0d wrong) expected %0d bytes", cap_bytes.size(), nbad, mdl_bytes.size()); end
        eth_serve(60, -1, 1'b1, got3);
        checks++;
        if (got3) begin errors++; $display("FAIL split_no_third: got udp_tx_en num=%0d expected none", udp_tx_data_num); end
        checks++;
        if (frame_pend !== 3'd0) begin errors++; $display("FAIL split_pend: got %0d expected 0", frame_pend); end
    endtask

    task automatic test_fill();
        bit ok;
        tx_rdy = 1'b0;
        for (int i = 0; i < c_buf_sz; i++) begin
            write_byte(8'($urandom), 1'b0, 5, ok);
            if (i == c_buf_sz - 2) begin
                checks++;
                if (wr_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy_2047: got %b expected 1", wr_rdy); end
            end
        end
        checks++;
        if (wr_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy_2048: got %b expected 0", wr_rdy); end
        checks++;
        if (int'(frame_pend) != mdl_lens.size()) begin errors++; $display("FAIL fill_pend: got %0d expected %0d", frame_pend, mdl_lens.size()); end
        write_byte(8'hAA, 1'b0, 5, ok);
        checks++;
        if (ok) begin errors++; $display("FAIL fill_overflow: got accept expected stall"); end
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 4; b++) write_byte(8'($urandom), b == 3, 5, ok);
            checks++;
            if (wr_rdy !== (mdl_lens.size() < c_lenq_sz)) begin
                errors++; $display("FAIL lenq_rdy[%0d]: got %b expected %b", f, wr_rdy, mdl_lens.size() < c_lenq_sz);
            end
        end
        checks++;
        if (frame_pend !== 3'd4) begin errors++; $display("FAIL lenq_pend: got %0d expected 4", frame_pend); end
        write_byte(8'h55, 1'b0, 5, ok);
        checks++;
        if (ok) begin errors++; $display("FAIL lenq_overflow: got accept expected stall"); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit got1;
        bit got2;
        bit got3;
        int nbad;
        tx_rdy = 1'b0;
        for (int b = 0; b < 4; b++) write_byte(8'($urandom), b == 3, 20, ok);
        for (int b = 0; b < 6; b++) write_byte(8'($urandom), b == 5, 20, ok);
        checks++;
        if (frame_pend !== 3'd2) begin errors++; $display("FAIL b2b_pend2: got %0d expected 2", frame_pend); end
        tx_rdy = 1'b1;
        eth_serve(20, -1, 1'b0, got1);
        eth_serve(20, -1, 1'b0, got2);
        checks++;
        if (!got1 || got2) begin errors++; $display("FAIL b2b_hold: got first=%b second=%b expected 1 0 while tx_rdy stays 1", got1, got2); end
        checks++;
        if (frame_pend !== 3'd1) begin errors++; $display("FAIL b2b_pend1: got %0d expected 1", frame_pend); end
        tx_rdy = 1'b0;
        tick();
        tx_rdy = 1'b1;
        eth_serve(20, -1, 1'b1, got3);
        checks++;
        if (!got3) begin errors++; $display("FAIL b2b_second_en: got none expected udp_tx_en after tx_rdy 0->1"); end
        nbad = (cap_lens.size() != mdl_lens.size()) ? 1 : 0;
        foreach (mdl_lens[i]) if (i >= cap_lens.size() || cap_lens[i] != mdl_lens[i]) nbad++;
        foreach (mdl_bytes[i]) if (i >= cap_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL b2b_frames: got %0d frames %0d bytes (%0d wrong) expected %0d frames %0d bytes", cap_lens.size(), cap_bytes.size(), nbad, mdl_lens.size(), mdl_bytes.size()); end
    endtask

    task automatic test_extra_req();
        bit ok;
        bit got1;
        bit got2;
        int nbad;
        tx_rdy = 1'b0;
        for (int b = 0; b < 10; b++) write_byte(8'($urandom), b == 9, 20, ok);
        for (int b = 0; b < 5; b++) write_byte(8'($urandom), b == 4, 20, ok);
        tx_rdy = 1'b1;
        eth_serve(20, -1, 1'b0, got1);
        checks++;
        if (req_err !== 1'b0) begin errors++; $display("FAIL extra_err_before: got %b expected 0", req_err); end
        udp_tx_req = 1'b1;
        tick();
        udp_tx_req = 1'b0;
        checks++;
        if (udp_tx_data !== 8'h00) begin errors++; $display("FAIL extra_data: got %h expected 00", udp_tx_data); end
        checks++;
        if (req_err !== 1'b1) begin errors++; $display("FAIL extra_err: got %b expected 1", req_err); end
        tx_rdy = 1'b0;
        tick();
        tx_rdy = 1'b1;
        eth_serve(20, -1, 1'b1, got2);
        nbad = (got1 && got2) ? 0 : 1;
        if (cap_lens.size() != mdl_lens.size()) nbad++;
        foreach (mdl_lens[i]) if (i >= cap_lens.size() || cap_lens[i] != mdl_lens[i]) nbad++;
        foreach (mdl_bytes[i]) if (i >= cap_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL extra_frames: got %0d frames %0d bytes (%0d wrong) expected %0d frames %0d bytes", cap_lens.size(), cap_bytes.size(), nbad, mdl_lens.size(), mdl_bytes.size()); end
        checks++;
        if (req_err !== 1'b1) begin errors++; $display("FAIL extra_err_sticky: got %b expected 1", req_err); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        bit got;
        int len;
        int nbad;
        tx_rdy = 1'b1;
        for (int b = 0; b < 10; b++) write_byte(8'($urandom), b == 9, 20, ok);
        eth_serve(20, 5, 1'b0, got);
        nbad = (got && cap_bytes.size() == 5) ? 0 : 1;
        foreach (cap_bytes[i]) if (i >= mdl_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL mid_partial: got %0d bytes (%0d wrong) expected 5 matching", cap_bytes.size(), nbad); end
        rst = 1'b1;
        tick();
        checks++;
        if ({wr_rdy, udp_tx_en, udp_tx_data_num, udp_tx_data, frame_pend, req_err} !== '0) begin
            errors++; $display("FAIL mid_rst_outputs: got rdy=%b en=%b num=%0d data=%h pend=%0d err=%b expected all 0", wr_rdy, udp_tx_en, udp_tx_data_num, udp_tx_data, frame_pend, req_err);
        end
        rst = 1'b0;
        clear_model();
        tick();
        checks++;
        if (wr_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy_after: got %b expected 1", wr_rdy); end
        checks++;
        if (frame_pend !== 3'd0) begin errors++; $display("FAIL mid_pend: got %0d expected 0", frame_pend); end
        len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) write_byte(8'($urandom), b == len - 1, 20, ok);
        eth_serve(20, -1, 1'b1, got);
        nbad = got ? 0 : 1;
        if (cap_lens.size() != 1 || cap_lens[0] != len) nbad++;
        if (cap_bytes.size() != mdl_bytes.size()) nbad++;
        foreach (mdl_bytes[i]) if (i >= cap_bytes.size() || cap_bytes[i] !== mdl_bytes[i]) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL mid_next_frame: got %0d bytes (%0d wrong) expected %0d", cap_bytes.size(), nbad, len); end
        checks++;
        if (req_err !== 1'b0) begin errors++; $display("FAIL mid_req_err: got %b expected 0", req_err); end
    endtask

    initial begin
        rst = 1'b1;
        wr_data = 8'h00;
        wr_vld = 1'b0;
        wr_last = 1'b0;
        tx_rdy = 1'b0;
        udp_tx_req = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_autosplit();
        do_reset();
        test_fill();
        test_back_to_back();
        do_reset();
        test_extra_req();
        do_reset();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
